reg_bank_arbiter: RTL and testbench

Round-robin write arbiter and storage controller for a small shared register bank built from D flip-flops. Up to NREQ requesters compete for the bank's single write port. The block picks one requester per clock, commits that requester's data into the addressed register and acknowledges the winner. It sits between the lab's requester modules (counters, input latches) and the shared register bank, and also provides one combinational read port.

---
 rtl/reg_bank_arbiter.sv | 68 ++++++
 tb/tb_reg_bank_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter for a small flip-flop register bank.
// One winner per clock is committed and acknowledged; reads are combinational.
module reg_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic [NREQ-1:0]       REQ,
   input  logic [NREQ*AW-1:0]    ADDR,
   input  logic [NREQ*WIDTH-1:0] DIN,
   output logic [NREQ-1:0]       ACK,
   input  logic [AW-1:0]         RADDR,
   output logic [WIDTH-1:0]      RDATA,
   output logic [7:0]            WCOUNT,
   output logic                  BUSY
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [WIDTH-1:0] bank [DEPTH];
   logic [LW-1:0]    last_grant;
   logic             win_valid;
   logic [LW-1:0]    win_idx;
   logic [LW-1:0]    scan_idx;
   logic [AW-1:0]    win_addr;
   logic [WIDTH-1:0] win_din;

   // Scan starts one past the previous winner so a repeat request goes to the back.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         scan_idx = LW'((int'(last_grant) + k) % NREQ);
         if (!win_valid && REQ[scan_idx]) begin
            win_valid = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   assign win_addr = ADDR[win_idx*AW +: AW];
   assign win_din  = DIN[win_idx*WIDTH +: WIDTH];
   assign RDATA    = bank[RADDR];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int d = 0; d < DEPTH; d++) bank[d] <= '0;
         ACK        <= '0;
         WCOUNT     <= '0;
         BUSY       <= 1'b0;
         last_grant <= LW'(NREQ - 1);
      end else begin
         BUSY <= |REQ;
         ACK  <= '0;
         if (win_valid) begin
            bank[win_addr] <= win_din;
            ACK            <= NREQ'(1) << win_idx;
            last_grant     <= win_idx;
            if (WCOUNT != 8'hFF) WCOUNT <= WCOUNT + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, single write, contention,
// repeat-request fairness, same-address collision, mid-cycle reset and saturation.
module tb_reg_bank_arbiter;

   logic        CLK;
   logic        RESET_N;
   logic [3:0]  REQ;
   logic [7:0]  ADDR;
   logic [31:0] DIN;
   logic [3:0]  ACK;
   logic [1:0]  RADDR;
   logic [7:0]  RDATA;
   logic [7:0]  WCOUNT;
   logic        BUSY;

   int checks;
   int errors;

   reg_bank_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(4), .AW(2)) dut (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .REQ    (REQ),
      .ADDR   (ADDR),
      .DIN    (DIN),
      .ACK    (ACK),
      .RADDR  (RADDR),
      .RDATA  (RDATA),
      .WCOUNT (WCOUNT),
      .BUSY   (BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
      ADDR[i*2 +: 2] = a;
      DIN[i*8 +: 8]  = d;
   endtask

   task automatic read_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
      RADDR = a;
      #1;
      check(tag, {24'd0, RDATA}, {24'd0, exp});
   endtask

   // Short reset pulse placed between edges, leaving REQ idle afterwards.
   task automatic reset_pulse();
      @(negedge CLK);
      REQ     = 4'b0000;
      RESET_N = 1'b0;
      #2;
      RESET_N = 1'b1;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      RESET_N = 1'b0;
      REQ     = 4'b1111;
      ADDR    = 8'hE4;
      DIN     = 32'h13121110;
      RADDR   = 2'd0;

      // Reset with all requests held
      #3;
      check("rst_ack", {28'd0, ACK}, 32'h0);
      check("rst_busy", {31'd0, BUSY}, 32'h0);
      check("rst_wcount", {24'd0, WCOUNT}, 32'h0);
      for (int a = 0; a < 4; a++) read_chk("rst_rdata", 2'(a), 8'h00);
      step();
      check("rst_hold_ack", {28'd0, ACK}, 32'h0);
      check("rst_hold_wcount", {24'd0, WCOUNT}, 32'h0);
      @(negedge CLK);
      REQ     = 4'b0000;
      RESET_N = 1'b1;

      // Single requester 2 writes A5 to address 3
      @(negedge CLK);
      set_req(2, 2'd3, 8'hA5);
      REQ = 4'b0100;
      read_chk("single_old", 2'd3, 8'h00);
      step();
      REQ = 4'b0000;
      check("single_ack", {28'd0, ACK}, 32'h4);
      check("single_busy", {31'd0, BUSY}, 32'h1);
      check("single_wcount", {24'd0, WCOUNT}, 32'd1);
      read_chk("single_rdata", 2'd3, 8'hA5);
      step();
      check("single_ack_drop", {28'd0, ACK}, 32'h0);
      check("single_busy_drop", {31'd0, BUSY}, 32'h0);

      // Full contention from reset
      reset_pulse();
      for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'h10 + 8'(i));
      REQ = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("full_ack%0d", k), {28'd0, ACK}, 32'(4'b0001 << (k % 4)));
      end
      REQ = 4'b0000;
      check("full_wcount", {24'd0, WCOUNT}, 32'd8);
      read_chk("full_b0", 2'd0, 8'h10);
      read_chk("full_b1", 2'd1, 8'h11);
      read_chk("full_b2", 2'd2, 8'h12);
      read_chk("full_b3", 2'd3, 8'h13);

      // Repeat request from requester 0 must yield to requester 1
      reset_pulse();
      set_req(0, 2'd0, 8'h01);
      set_req(1, 2'd1, 8'h02);
      REQ = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("rpt_ack%0d", k), {28'd0, ACK}, (k % 2 == 0) ? 32'h1 : 32'h2);
      end
      REQ = 4'b0000;

      // Same-address collision: 1 then 3 write address 0
      reset_pulse();
      set_req(1, 2'd0, 8'h11);
      set_req(3, 2'd0, 8'h33);
      REQ = 4'b1010;
      step();
      check("coll_ack1", {28'd0, ACK}, 32'h2);
      read_chk("coll_b0_first", 2'd0, 8'h11);
      step();
      REQ = 4'b0000;
      check("coll_ack2", {28'd0, ACK}, 32'h8);
      read_chk("coll_b0_final", 2'd0, 8'h33);

      // Reset asserted while ACK is high
      @(negedge CLK);
      set_req(0, 2'd2, 8'h5A);
      REQ = 4'b0001;
      step();
      check("mid_ack_before", {28'd0, ACK}, 32'h1);
      read_chk("mid_b2_before", 2'd2, 8'h5A);
      RESET_N = 1'b0;
      #1;
      check("mid_ack_cleared", {28'd0, ACK}, 32'h0);
      check("mid_wcount_cleared", {24'd0, WCOUNT}, 32'h0);
      read_chk("mid_b2_cleared", 2'd2, 8'h00);
      @(negedge CLK);
      RESET_N = 1'b1;

      // Saturation with a continuous single requester
      for (int k = 1; k <= 300; k++) begin
         step();
         if (k == 254) check("sat_254", {24'd0, WCOUNT}, 32'd254);
         if (k == 255) check("sat_255", {24'd0, WCOUNT}, 32'd255);
         if (k == 256) check("sat_256", {24'd0, WCOUNT}, 32'd255);
      end
      check("sat_300", {24'd0, WCOUNT}, 32'd255);
      check("sat_ack", {28'd0, ACK}, 32'h1);
      REQ = 4'b0000;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
